// File: rtl/serializer_pkg.sv
// serializer_pkg: shared state encoding and counter sizing for the PISO serializer.
package serializer_pkg;
    typedef enum logic {S_IDLE, S_SHIFT} state_e;
    function automatic int cnt_w(input int width);
        return $clog2(width + 2);
    endfunction
endpackage

// File: rtl/bit_serializer_piso.sv
// bit_serializer_piso: MSB-first PISO feeding the sequence detector, zero-bubble back-to-back words.
// SERIALIZER_PARITY_EN appends an even-parity bit captured at accept time as the final serial bit.
module bit_serializer_piso
    import serializer_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             busy
);
`ifdef SERIALIZER_PARITY_EN
    localparam int NBITS = WIDTH + 1;
`else
    localparam int NBITS = WIDTH;
`endif
    localparam int CW = cnt_w(WIDTH);
    state_e           state_q, state_d;
    logic [NBITS-1:0] sr_q, sr_d, word;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             accept, last;
`ifdef SERIALIZER_PARITY_EN
    assign word = {load_data, ^load_data};
`else
    assign word = load_data;
`endif
    assign last   = cnt_q == '0;
    assign accept = load_valid && load_ready;
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
        end
    end
    // A reload on the last bit keeps us in SHIFT, giving a gapless stream.
    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        if (accept) begin
            state_d = S_SHIFT;
            sr_d    = word;
            cnt_d   = CW'(NBITS - 1);
        end else if (state_q == S_SHIFT) begin
            state_d = last ? S_IDLE : S_SHIFT;
            sr_d    = {sr_q[NBITS-2:0], 1'b0};
            cnt_d   = last ? cnt_q : cnt_q - 1'b1;
        end
    end
    // Idle ser_out is forced low so the detector never sees a spurious 1.
    always_comb begin
        busy       = state_q == S_SHIFT;
        ser_valid  = busy;
        ser_out    = busy && sr_q[NBITS-1];
        load_ready = reset && (!busy || last);
    end
endmodule

// File: tb/tb_bit_serializer_piso.sv
// tb_bit_serializer_piso: directed and random stimulus against a bit-queue model of the serial stream.
module tb_bit_serializer_piso;
    localparam int W = 4;
`ifdef SERIALIZER_PARITY_EN
    localparam int NB = W + 1;
`else
    localparam int NB = W;
`endif
    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         load_valid = 1'b0;
    logic [W-1:0] load_data = '0;
    logic         load_ready, ser_out, ser_valid, busy;
    int           compared = 0;
    int           mismatched = 0;
    bit           q[$];

    always #5 clk = ~clk;

    bit_serializer_piso #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .load_data(load_data), .load_valid(load_valid),
        .load_ready(load_ready), .ser_out(ser_out), .ser_valid(ser_valid), .busy(busy)
    );

    task automatic check(input string tag, input logic obs, input logic exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %b expected %b at %0t", tag, obs, exp, $time);
        end
    endtask

    // q[0] is the bit that must be on ser_out this cycle; the rest follow in order.
    task automatic step(input logic rst, input logic v, input logic [W-1:0] d, input bit full = 1'b1);
        logic acc;
        reset = rst;
        load_valid = v;
        load_data = d;
        #3;
        check("load_ready", load_ready, rst && q.size() <= 1);
        if (full) begin
            check("ser_valid", ser_valid, q.size() > 0);
            check("busy", busy, q.size() > 0);
            check("ser_out", ser_out, q.size() > 0 ? q[0] : 1'b0);
        end
        acc = rst && v && q.size() <= 1;
        @(posedge clk);
        if (!rst) q.delete();
        else begin
            if (q.size() > 0) void'(q.pop_front());
            if (acc) begin
                for (int i = W - 1; i >= 0; i--) q.push_back(d[i]);
`ifdef SERIALIZER_PARITY_EN
                q.push_back(^d);
`endif
            end
        end
        #1;
    endtask

    initial begin
        logic         v, r, acc;
        logic [W-1:0] cur;
        step(1'b0, 1'b1, 4'hF, 1'b0);
        step(1'b0, 1'b1, 4'hF);
        step(1'b1, 1'b1, 4'b1101);
        for (int i = 0; i < NB + 2; i++) step(1'b1, 1'b0, 4'h0);
        step(1'b1, 1'b1, 4'b1101);
        for (int i = 0; i < NB; i++) step(1'b1, 1'b1, 4'b1011);
        for (int i = 0; i < NB + 2; i++) step(1'b1, 1'b0, 4'h0);
        step(1'b1, 1'b1, 4'b1001);
        step(1'b1, 1'b0, 4'h0);
        for (int i = 0; i < NB - 1; i++) step(1'b1, 1'b1, 4'b0110);
        for (int i = 0; i < NB + 2; i++) step(1'b1, 1'b0, 4'h0);
        step(1'b1, 1'b1, 4'b1110);
        step(1'b1, 1'b0, 4'h0);
        step(1'b1, 1'b0, 4'h0);
        step(1'b0, 1'b1, 4'hF);
        step(1'b1, 1'b0, 4'h0);
        step(1'b1, 1'b1, 4'b1001);
        for (int i = 0; i < NB + 2; i++) step(1'b1, 1'b0, 4'h0);
        v = 1'b0;
        cur = W'($urandom);
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 39) != 0;
            acc = r && v && q.size() <= 1;
            step(r, v, cur);
            if (acc) cur = W'($urandom);
            if (!v || acc || !r) v = $urandom_range(0, 3) != 0;
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
